// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
//   ID-stage hazard / stall controller sitting in front of the forwarding
//   units. It detects the data hazards forwarding cannot cover (load-use,
//   and branch/JR operands still being produced in EX or loaded in MEM).
//   For those it holds PC and IF/ID and injects a bubble into ID/EX. It
//   flushes IF/ID on a taken branch or jump, and freezes the whole pipe
//   while data memory is busy. A branch whose operand is a load still in EX
//   needs BR_LOAD_STALL cycles; the extra cycles are sequenced by a small
//   IDLE/HOLD FSM. Stall and flush cycles are counted in saturating
//   counters.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   IF_ID_RegRs/RegRt/UseRt       source registers of the ID instruction
//   Branch, JR, Jump, BranchTaken control-flow info of the ID instruction
//   ID_EX_RW/MR/RegRd             write/load/destination of EX instruction
//   EX_MEM_MR/RegRd               load/destination of MEM instruction
//   MemBusy                       data memory not ready -> full freeze
//   PC_Write, IF_ID_Write         pipeline enables
//   IF_ID_Flush, ID_EX_Flush      bubble insertion
//   Stall_Cnt, Flush_Cnt          saturating performance counters
// ---------------------------------------------------------------------------
module hazard_stall_ctrl #(
  parameter int         BR_LOAD_STALL = 2,
  parameter int         CNT_W         = 32,
  parameter logic [3:0] NOT_BRANCH    = 4'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IF_ID_RegRs,
  input  logic [4:0]       IF_ID_RegRt,
  input  logic             IF_ID_UseRt,
  input  logic [3:0]       Branch,
  input  logic             JR,
  input  logic             Jump,
  input  logic             BranchTaken,
  input  logic             ID_EX_RW,
  input  logic [2:0]       ID_EX_MR,
  input  logic [4:0]       ID_EX_RegRd,
  input  logic [2:0]       EX_MEM_MR,
  input  logic [4:0]       EX_MEM_RegRd,
  input  logic             MemBusy,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic [CNT_W-1:0] Stall_Cnt,
  output logic [CNT_W-1:0] Flush_Cnt
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Cycles still to spend in HOLD after the first (IDLE) stall cycle.
  localparam int         HOLD_INIT_I = (BR_LOAD_STALL > 1) ? (BR_LOAD_STALL - 2) : 0;
  localparam logic [1:0] HOLD_INIT   = 2'(HOLD_INIT_I);
  localparam bit         MULTI_STALL = (BR_LOAD_STALL > 1);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q;
  logic [1:0]       hold_left_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  logic is_br_s;
  logic src_ex_s;
  logic src_mem_s;
  logic lu_s, ba_s, blm_s, ble_s;
  logic stall_s;
  logic pc_write_s, if_id_write_s, if_id_flush_s, id_ex_flush_s;

  // $0 is hardwired zero, so it never matches as a hazard.
  function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] r);
    return (rd != 5'd0) && (rd == r);
  endfunction

  // Hazard detection on the instruction currently in ID.
  always_comb begin
    is_br_s   = (Branch != NOT_BRANCH) || JR;
    src_ex_s  = reg_match(ID_EX_RegRd, IF_ID_RegRs) ||
                (IF_ID_UseRt && reg_match(ID_EX_RegRd, IF_ID_RegRt));
    src_mem_s = reg_match(EX_MEM_RegRd, IF_ID_RegRs) ||
                (IF_ID_UseRt && reg_match(EX_MEM_RegRd, IF_ID_RegRt));
    lu_s  = !is_br_s && (ID_EX_MR != 3'd0) && src_ex_s;
    ba_s  = is_br_s && ID_EX_RW && (ID_EX_MR == 3'd0) && src_ex_s;
    blm_s = is_br_s && (EX_MEM_MR != 3'd0) && src_mem_s;
    ble_s = is_br_s && (ID_EX_MR != 3'd0) && src_ex_s;
    // HOLD stalls unconditionally; hazards are only looked at in IDLE.
    stall_s = (state_q == ST_HOLD) || (lu_s || ba_s || blm_s || ble_s);
  end

  // Pipeline control outputs, priority reset > freeze > stall > flush > run.
  always_comb begin
    pc_write_s    = 1'b1;
    if_id_write_s = 1'b1;
    if_id_flush_s = 1'b0;
    id_ex_flush_s = 1'b0;
    if (rst) begin
      pc_write_s    = 1'b1;
      if_id_write_s = 1'b1;
    end else if (MemBusy) begin
      pc_write_s    = 1'b0;
      if_id_write_s = 1'b0;
    end else if (stall_s) begin
      // Branch outcome is not trusted here: its operands are not ready yet.
      pc_write_s    = 1'b0;
      if_id_write_s = 1'b0;
      id_ex_flush_s = 1'b1;
    end else if (BranchTaken || Jump) begin
      if_id_flush_s = 1'b1;
    end else begin
      pc_write_s    = 1'b1;
      if_id_write_s = 1'b1;
    end
  end

  // Multi-cycle stall sequencer for branch-on-load-in-EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hold_left_q <= 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ble_s && MULTI_STALL && !MemBusy) begin
            state_q     <= ST_HOLD;
            hold_left_q <= HOLD_INIT;
          end else begin
            state_q     <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (!MemBusy && (hold_left_q == 2'd0)) begin
            state_q <= ST_IDLE;
          end else if (!MemBusy) begin
            hold_left_q <= hold_left_q - 2'd1;
          end else begin
            hold_left_q <= hold_left_q;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          hold_left_q <= 2'd0;
        end
      endcase
    end
  end

  // Saturating stall/flush performance counters; frozen cycles do not count.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!MemBusy && stall_s && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + CNT_ONE;
      end
      if (if_id_flush_s && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_q <= flush_cnt_q + CNT_ONE;
      end
    end
  end

  assign PC_Write    = pc_write_s;
  assign IF_ID_Write = if_id_write_s;
  assign IF_ID_Flush = if_id_flush_s;
  assign ID_EX_Flush = id_ex_flush_s;
  assign Stall_Cnt   = stall_cnt_q;
  assign Flush_Cnt   = flush_cnt_q;

endmodule
